// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and sizing helpers for pipeline boundary registers
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_t;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_NUM_DATA   = 2;
    localparam int DEFAULT_CTRL_WIDTH = 2;

    // Payload is packed as {ctrl, data}
    function automatic int payload_w(input int ctrl_width, input int num_data, input int data_width);
        return ctrl_width + num_data * data_width;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - upstream/downstream handshake bundle of a pipeline boundary register
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_DATA   = DEFAULT_NUM_DATA,
    parameter int CTRL_WIDTH = DEFAULT_CTRL_WIDTH
);
    logic                           flush;
    logic                           in_valid;
    logic                           in_ready;
    logic [CTRL_WIDTH-1:0]          in_ctrl;
    logic [NUM_DATA*DATA_WIDTH-1:0] in_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [CTRL_WIDTH-1:0]          out_ctrl;
    logic [NUM_DATA*DATA_WIDTH-1:0] out_data;
    logic [1:0]                     occupancy;

    // master drives the stage (pipeline control side), slave is the stage itself
    modport master (
        output flush, in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, occupancy
    );

    modport slave (
        input  flush, in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, occupancy
    );

endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline boundary register with optional 2-entry skid buffer
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_DATA   = DEFAULT_NUM_DATA,
    parameter int CTRL_WIDTH = DEFAULT_CTRL_WIDTH,
    parameter int SKID       = 1
) (
    input logic                clk,
    input logic                rst,
    pipe_stage_reg_if.slave    bus
);

    localparam int DATA_ALL_W = NUM_DATA * DATA_WIDTH;
    localparam int PW         = payload_w(CTRL_WIDTH, NUM_DATA, DATA_WIDTH);

    pipe_state_t   state_q, state_d;
    logic [PW-1:0] main_q, main_d;
    logic [PW-1:0] skid_q, skid_d;
    logic [PW-1:0] in_payload;
    logic          in_ready;
    logic          out_valid;
    logic          in_fire;
    logic          out_fire;

    assign in_payload = {bus.in_ctrl, bus.in_data};
    assign out_valid  = (state_q != ST_EMPTY);
    assign in_fire    = bus.in_valid && in_ready;
    assign out_fire   = out_valid && bus.out_ready;

    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = (state_q != ST_TWO);
        end else begin : g_noskid
            assign in_ready = !out_valid || bus.out_ready;
        end
    endgenerate

    // Whenever the stage goes empty the ctrl field is zeroed so a bubble never carries write-enables
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush) begin
            state_d                    = ST_EMPTY;
            main_d[PW-1 -: CTRL_WIDTH] = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = in_payload;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_payload;
                    end else if (in_fire && (SKID != 0)) begin
                        state_d = ST_TWO;
                        skid_d  = in_payload;
                    end else if (out_fire) begin
                        state_d                    = ST_EMPTY;
                        main_d[PW-1 -: CTRL_WIDTH] = '0;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d                    = ST_EMPTY;
                    main_d[PW-1 -: CTRL_WIDTH] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_ctrl  = main_q[PW-1 -: CTRL_WIDTH];
    assign bus.out_data  = main_q[DATA_ALL_W-1:0];
    assign bus.occupancy = 2'(state_q);

    a_no_fire_when_full: assert property (@(posedge clk) disable iff (rst)
        !(in_fire && !in_ready));

    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !bus.out_ready && !bus.flush) |=> (out_valid && $stable(main_q)));

    a_occ_noskid: assert property (@(posedge clk) disable iff (rst)
        (SKID != 0) || (state_q != ST_TWO));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed and scoreboard checks of pipe_stage_reg for SKID=1 and SKID=0
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int DW = 32;
    localparam int ND = 2;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic in_valid;
    logic out_ready1;
    logic out_ready0;
    logic [CW-1:0]    in_ctrl;
    logic [ND*DW-1:0] in_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_WIDTH(DW), .NUM_DATA(ND), .CTRL_WIDTH(CW)) if1 ();
    pipe_stage_reg_if #(.DATA_WIDTH(DW), .NUM_DATA(ND), .CTRL_WIDTH(CW)) if0 ();

    assign if1.flush     = flush;
    assign if1.in_valid  = in_valid;
    assign if1.in_ctrl   = in_ctrl;
    assign if1.in_data   = in_data;
    assign if1.out_ready = out_ready1;
    assign if0.flush     = flush;
    assign if0.in_valid  = in_valid;
    assign if0.in_ctrl   = in_ctrl;
    assign if0.in_data   = in_data;
    assign if0.out_ready = out_ready0;

    pipe_stage_reg #(.DATA_WIDTH(DW), .NUM_DATA(ND), .CTRL_WIDTH(CW), .SKID(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    pipe_stage_reg #(.DATA_WIDTH(DW), .NUM_DATA(ND), .CTRL_WIDTH(CW), .SKID(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ND*DW-1:0] word(input int k);
        word = {32'(k + 256), 32'(k)};
    endfunction

    function automatic logic [CW-1:0] ctl(input int k);
        ctl = 2'((k % 3) + 1);
    endfunction

    task automatic drive(input int k);
        in_valid = 1'b1;
        in_ctrl  = ctl(k);
        in_data  = word(k);
    endtask

    logic [CW+ND*DW-1:0] q1[$];
    logic [CW+ND*DW-1:0] q0[$];

    initial begin
        // Reset with a live input pattern that must be ignored
        rst = 1'b1; flush = 1'b0; out_ready1 = 1'b1; out_ready0 = 1'b1;
        in_valid = 1'b1; in_ctrl = 2'b11; in_data = word(99);
        tick();
        tick();
        chk("rst_out_valid1", if1.out_valid, 0);
        chk("rst_out_ctrl1", if1.out_ctrl, 0);
        chk("rst_out_data1", if1.out_data, 0);
        chk("rst_occ1", if1.occupancy, 0);
        chk("rst_out_valid0", if0.out_valid, 0);
        chk("rst_occ0", if0.occupancy, 0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        chk("rst_in_ready1", if1.in_ready, 1);
        chk("rst_in_ready0", if0.in_ready, 1);

        // Back-to-back streaming, 1-cycle latency, in_ready never drops
        for (int k = 1; k <= 8; k++) begin
            drive(k);
            #2;
            chk($sformatf("stream_in_ready1_%0d", k), if1.in_ready, 1);
            chk($sformatf("stream_in_ready0_%0d", k), if0.in_ready, 1);
            tick();
            chk($sformatf("stream_out1_%0d", k), {if1.out_valid, if1.out_ctrl, if1.out_data}, {1'b1, ctl(k), word(k)});
            chk($sformatf("stream_out0_%0d", k), {if0.out_valid, if0.out_ctrl, if0.out_data}, {1'b1, ctl(k), word(k)});
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain_valid1", if1.out_valid, 0);
        chk("stream_drain_ctrl1", if1.out_ctrl, 0);
        chk("stream_drain_valid0", if0.out_valid, 0);
        chk("stream_drain_ctrl0", if0.out_ctrl, 0);

        // Stall into the skid register, then release
        out_ready1 = 1'b0; out_ready0 = 1'b0;
        drive(10);
        tick();
        drive(11);
        tick();
        in_valid = 1'b0;
        chk("stall_occ1", if1.occupancy, 2);
        chk("stall_in_ready1", if1.in_ready, 0);
        chk("stall_occ0", if0.occupancy, 1);
        tick();
        chk("stall_hold1", {if1.out_valid, if1.out_ctrl, if1.out_data}, {1'b1, ctl(10), word(10)});
        chk("stall_hold0", {if0.out_valid, if0.out_data}, {1'b1, word(10)});
        out_ready1 = 1'b1; out_ready0 = 1'b1;
        tick();
        chk("release_b1", {if1.out_valid, if1.out_ctrl, if1.out_data}, {1'b1, ctl(11), word(11)});
        chk("release_occ1", if1.occupancy, 1);
        chk("release_in_ready1", if1.in_ready, 1);
        tick();
        chk("release_empty1", if1.out_valid, 0);
        chk("release_empty0", if0.out_valid, 0);

        // Flush with two held entries and a pending input
        out_ready1 = 1'b0; out_ready0 = 1'b0;
        drive(20);
        tick();
        drive(21);
        tick();
        chk("flush_pre_occ1", if1.occupancy, 2);
        drive(22);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid1", if1.out_valid, 0);
        chk("flush_ctrl1", if1.out_ctrl, 0);
        chk("flush_occ1", if1.occupancy, 0);
        chk("flush_valid0", if0.out_valid, 0);
        chk("flush_ctrl0", if0.out_ctrl, 0);
        chk("flush_occ0", if0.occupancy, 0);
        out_ready1 = 1'b1; out_ready0 = 1'b1;
        tick();
        chk("flush_no_c1", if1.out_valid, 0);
        chk("flush_no_c0", if0.out_valid, 0);

        // Flush from empty drops a same-cycle accepted input
        drive(23);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_drop_valid1", if1.out_valid, 0);
        chk("flush_drop_valid0", if0.out_valid, 0);
        chk("flush_drop_occ1", if1.occupancy, 0);

        // Simultaneous accept and retire while holding one entry
        drive(30);
        tick();
        drive(31);
        tick();
        in_valid = 1'b0;
        chk("simul_out1", {if1.out_valid, if1.out_ctrl, if1.out_data}, {1'b1, ctl(31), word(31)});
        chk("simul_occ1", if1.occupancy, 1);
        chk("simul_out0", {if0.out_valid, if0.out_ctrl, if0.out_data}, {1'b1, ctl(31), word(31)});
        chk("simul_occ0", if0.occupancy, 1);
        tick();
        chk("simul_empty1", if1.out_valid, 0);

        // Random traffic against per-instance queue scoreboards
        q1.delete();
        q0.delete();
        for (int c = 0; c < 3000; c++) begin
            flush      = ($urandom_range(0, 99) < 5);
            in_valid   = 1'($urandom_range(0, 1));
            out_ready1 = 1'($urandom_range(0, 1));
            out_ready0 = 1'($urandom_range(0, 1));
            in_ctrl    = 2'($urandom);
            in_data    = {$urandom, $urandom};
            #2;
            chk("rnd_valid1", if1.out_valid, q1.size() != 0);
            chk("rnd_valid0", if0.out_valid, q0.size() != 0);
            if (flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (if1.out_valid && out_ready1 && q1.size() != 0) begin
                    chk("rnd_out1", {if1.out_ctrl, if1.out_data}, q1[0]);
                    void'(q1.pop_front());
                end
                if (in_valid && if1.in_ready) q1.push_back({in_ctrl, in_data});
                if (if0.out_valid && out_ready0 && q0.size() != 0) begin
                    chk("rnd_out0", {if0.out_ctrl, if0.out_data}, q0[0]);
                    void'(q0.pop_front());
                end
                if (in_valid && if0.in_ready) q0.push_back({in_ctrl, in_data});
            end
            tick();
            chk("rnd_occ1", if1.occupancy, q1.size());
            chk("rnd_occ0", if0.occupancy, q0.size());
            if (!if1.out_valid) chk("rnd_bubble1", if1.out_ctrl, 0);
            if (!if0.out_valid) chk("rnd_bubble0", if0.out_ctrl, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
